// File: rtl/instr_fetch_unit.sv
// Program-side fetch responder: PC, IR and instruction memory, with a boot loader
// that holds the controller in reset until a program has been streamed in.
module instr_fetch_unit #(
    parameter int PC_W    = 7,
    parameter int INSTR_W = 16
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               PC_clr,
    input  logic               IR_ld,
    input  logic               PC_up,
    input  logic               Reload,
    input  logic               Ld_valid,
    input  logic [INSTR_W-1:0] Ld_data,
    input  logic               Ld_last,
    output logic               Ld_ready,
    output logic               Core_ResetN,
    output logic [INSTR_W-1:0] IR,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W:0]      Ld_count
);
    localparam int            DEPTH   = 1 << PC_W;
    localparam logic [PC_W:0] CNT_MAX = (PC_W+1)'(DEPTH);

    typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     pc_q, pc_nxt, wr_ptr;
    logic [PC_W:0]       ld_cnt;
    logic [INSTR_W-1:0]  ir_q, rd_q;
    logic                core_rst_n_q;
    logic                we;
    logic [INSTR_W-1:0]  mem [DEPTH];

    assign Ld_ready    = (state == S_LOAD);
    assign Core_ResetN = core_rst_n_q;
    assign IR          = ir_q;
    assign PC          = pc_q;
    assign Ld_count    = ld_cnt;

    // A word arriving together with Reload is dropped: the load restarts from 0.
    assign we = Ld_valid & Ld_ready & ~Reload;

    always_comb begin
        state_nxt = state;
        if (Reload)
            state_nxt = S_LOAD;
        else if (we && Ld_last)
            state_nxt = S_RUN;
    end

    always_comb begin
        pc_nxt = pc_q;
        if (Reload || state == S_LOAD)
            pc_nxt = '0;
        else if (PC_clr)
            pc_nxt = '0;
        else if (PC_up)
            pc_nxt = pc_q + 1'b1;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state        <= S_LOAD;
            pc_q         <= '0;
            ir_q         <= '0;
            wr_ptr       <= '0;
            ld_cnt       <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc_q         <= pc_nxt;
            core_rst_n_q <= (state_nxt == S_RUN);
            if (state == S_RUN && IR_ld && !Reload)
                ir_q <= rd_q;
            if (Reload) begin
                wr_ptr <= '0;
                ld_cnt <= '0;
            end else if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (ld_cnt != CNT_MAX)
                    ld_cnt <= ld_cnt + 1'b1;
            end
        end
    end

    // Read is addressed by pc_nxt so rd_q tracks mem[PC]; same-address writes bypass.
    always_ff @(posedge Clock) begin
        if (we)
            mem[wr_ptr] <= Ld_data;
        if (we && wr_ptr == pc_nxt)
            rd_q <= Ld_data;
        else
            rd_q <= mem[pc_nxt];
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: loader handshake, controller fetch sequence,
// PC wrap/priority, Reload and asynchronous reset.
module tb_instr_fetch_unit;
    logic        Clock = 1'b0;
    logic        ResetN, PC_clr, IR_ld, PC_up, Reload, Ld_valid, Ld_last;
    logic [15:0] Ld_data;
    logic        Ld_ready, Core_ResetN;
    logic [15:0] IR;
    logic [6:0]  PC;
    logic [7:0]  Ld_count;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(.PC_W(7), .INSTR_W(16)) dut (
        .Clock(Clock), .ResetN(ResetN), .PC_clr(PC_clr), .IR_ld(IR_ld), .PC_up(PC_up),
        .Reload(Reload), .Ld_valid(Ld_valid), .Ld_data(Ld_data), .Ld_last(Ld_last),
        .Ld_ready(Ld_ready), .Core_ResetN(Core_ResetN), .IR(IR), .PC(PC), .Ld_count(Ld_count)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset();
        ResetN = 1'b0; PC_clr = 0; IR_ld = 0; PC_up = 0; Reload = 0;
        Ld_valid = 0; Ld_last = 0; Ld_data = '0;
        tick(); tick();
        ResetN = 1'b1;
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        Ld_valid = 1'b1; Ld_data = d; Ld_last = last;
        tick();
        Ld_valid = 1'b0; Ld_last = 1'b0;
    endtask

    // Controller fetch: IR_ld with PC_up, then one idle cycle.
    task automatic fetch();
        IR_ld = 1'b1; PC_up = 1'b1;
        tick();
        IR_ld = 1'b0; PC_up = 1'b0;
        tick();
    endtask

    task automatic pc_clear();
        PC_clr = 1'b1;
        tick();
        PC_clr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (Ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", Ld_ready); end
        total++; if (Core_ResetN !== 1'b0) begin bad++; $display("FAIL reset_core got=%0b exp=0", Core_ResetN); end
        total++; if (PC !== 7'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", PC); end
        total++; if (IR !== 16'h0) begin bad++; $display("FAIL reset_ir got=%h exp=0000", IR); end
        total++; if (Ld_count !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", Ld_count); end
    endtask

    task automatic test_load_fetch();
        logic [15:0] prog [3];
        prog[0] = 16'h2153; prog[1] = 16'h3234; prog[2] = 16'h5000;
        apply_reset();
        load_word(prog[0], 1'b0);
        load_word(prog[1], 1'b0);
        total++; if (Core_ResetN !== 1'b0) begin bad++; $display("FAIL t1_core_low got=%0b exp=0", Core_ResetN); end
        load_word(prog[2], 1'b1);
        total++; if (Ld_count !== 8'd3) begin bad++; $display("FAIL t1_cnt got=%0d exp=3", Ld_count); end
        total++; if (Core_ResetN !== 1'b1) begin bad++; $display("FAIL t1_core_high got=%0b exp=1", Core_ResetN); end
        total++; if (Ld_ready !== 1'b0) begin bad++; $display("FAIL t1_ready got=%0b exp=0", Ld_ready); end
        pc_clear();
        for (int i = 0; i < 3; i++) begin
            fetch();
            total++; if (IR !== prog[i]) begin bad++; $display("FAIL t1_ir%0d got=%h exp=%h", i, IR, prog[i]); end
            total++; if (PC !== 7'(i + 1)) begin bad++; $display("FAIL t1_pc%0d got=%0d exp=%0d", i, PC, i + 1); end
        end
    endtask

    task automatic test_valid_gaps();
        logic [15:0] expv [3];
        expv[0] = 16'h0A0A; expv[1] = 16'h0B0B; expv[2] = 16'h5000;
        apply_reset();
        Ld_valid = 1'b1; Ld_data = expv[0]; Ld_last = 1'b0;
        tick();
        Ld_valid = 1'b0; Ld_data = 16'hDEAD;
        tick();
        Ld_valid = 1'b1; Ld_data = expv[1]; Ld_last = 1'b1;
        tick();
        Ld_last = 1'b0; Ld_data = 16'hDEAD;
        tick(); tick(); tick();
        Ld_valid = 1'b0;
        total++; if (Ld_count !== 8'd2) begin bad++; $display("FAIL t2_cnt got=%0d exp=2", Ld_count); end
        total++; if (Ld_ready !== 1'b0) begin bad++; $display("FAIL t2_ready got=%0b exp=0", Ld_ready); end
        pc_clear();
        // Address 2 still holds the previous program's word.
        for (int i = 0; i < 3; i++) begin
            fetch();
            total++; if (IR !== expv[i]) begin bad++; $display("FAIL t2_ir%0d got=%h exp=%h", i, IR, expv[i]); end
        end
    endtask

    task automatic test_single_word();
        apply_reset();
        load_word(16'h1135, 1'b1);
        IR_ld = 1'b1;
        tick();
        IR_ld = 1'b0;
        total++; if (IR !== 16'h1135) begin bad++; $display("FAIL t3_ir got=%h exp=1135", IR); end
        total++; if (PC !== 7'd0) begin bad++; $display("FAIL t3_pc got=%0d exp=0", PC); end
    endtask

    task automatic test_pc_wrap();
        pc_clear();
        PC_up = 1'b1;
        for (int i = 0; i < 127; i++) tick();
        PC_up = 1'b0;
        total++; if (PC !== 7'd127) begin bad++; $display("FAIL t4_pc127 got=%0d exp=127", PC); end
        PC_up = 1'b1;
        tick();
        PC_up = 1'b0;
        total++; if (PC !== 7'd0) begin bad++; $display("FAIL t4_wrap got=%0d exp=0", PC); end
        PC_up = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        PC_up = 1'b0;
        total++; if (PC !== 7'd5) begin bad++; $display("FAIL t4_pc5 got=%0d exp=5", PC); end
        PC_clr = 1'b1; PC_up = 1'b1;
        tick();
        PC_clr = 1'b0; PC_up = 1'b0;
        total++; if (PC !== 7'd0) begin bad++; $display("FAIL t4_clr_prio got=%0d exp=0", PC); end
    endtask

    task automatic test_reload();
        apply_reset();
        load_word(16'h2153, 1'b0);
        load_word(16'h3234, 1'b0);
        load_word(16'h5000, 1'b1);
        pc_clear();
        fetch(); fetch();
        total++; if (PC !== 7'd2) begin bad++; $display("FAIL t5_pre_pc got=%0d exp=2", PC); end
        // Commands presented with Reload must lose.
        Reload = 1'b1; IR_ld = 1'b1; PC_up = 1'b1;
        tick();
        Reload = 1'b0; IR_ld = 1'b0; PC_up = 1'b0;
        total++; if (Core_ResetN !== 1'b0) begin bad++; $display("FAIL t5_core got=%0b exp=0", Core_ResetN); end
        total++; if (PC !== 7'd0) begin bad++; $display("FAIL t5_pc got=%0d exp=0", PC); end
        total++; if (Ld_count !== 8'd0) begin bad++; $display("FAIL t5_cnt got=%0d exp=0", Ld_count); end
        total++; if (Ld_ready !== 1'b1) begin bad++; $display("FAIL t5_ready got=%0b exp=1", Ld_ready); end
        total++; if (IR !== 16'h3234) begin bad++; $display("FAIL t5_ir_hold got=%h exp=3234", IR); end
        load_word(16'hAAAA, 1'b0);
        load_word(16'h0BBB, 1'b1);
        total++; if (Core_ResetN !== 1'b1) begin bad++; $display("FAIL t5_core_run got=%0b exp=1", Core_ResetN); end
        fetch();
        total++; if (IR !== 16'hAAAA) begin bad++; $display("FAIL t5_ir0 got=%h exp=aaaa", IR); end
        total++; if (PC !== 7'd1) begin bad++; $display("FAIL t5_pc1 got=%0d exp=1", PC); end
        fetch();
        total++; if (IR !== 16'h0BBB) begin bad++; $display("FAIL t5_ir1 got=%h exp=0bbb", IR); end
    endtask

    task automatic test_async_reset();
        // Re-enter LOAD via Reload so IR is non-zero when ResetN drops.
        Reload = 1'b1;
        tick();
        Reload = 1'b0;
        for (int i = 0; i < 4; i++) load_word(16'h4000 + 16'(i), 1'b0);
        total++; if (Ld_count !== 8'd4) begin bad++; $display("FAIL t6_cnt4 got=%0d exp=4", Ld_count); end
        #2 ResetN = 1'b0;
        #1;
        total++; if (Ld_count !== 8'd0) begin bad++; $display("FAIL t6_async_cnt got=%0d exp=0", Ld_count); end
        total++; if (IR !== 16'h0) begin bad++; $display("FAIL t6_async_ir got=%h exp=0000", IR); end
        total++; if (Core_ResetN !== 1'b0) begin bad++; $display("FAIL t6_async_core got=%0b exp=0", Core_ResetN); end
        #5 ResetN = 1'b1;
        tick();
        load_word(16'h7777, 1'b1);
        total++; if (Ld_count !== 8'd1) begin bad++; $display("FAIL t6_cnt1 got=%0d exp=1", Ld_count); end
        fetch();
        total++; if (IR !== 16'h7777) begin bad++; $display("FAIL t6_ir got=%h exp=7777", IR); end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_valid_gaps();
        test_single_word();
        test_pc_wrap();
        test_reload();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
